// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing one result bit per clock.
// hi_out/lo_out feed the HI/LO registers; done is their load enable.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             divide_by_zero
);

    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t             state_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic [CNT_W-1:0]   count_r;
    logic [DW-1:0]      work_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               is_signed_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     rem_ext_s;
    logic [WIDTH:0]     diff_s;
    logic [DW-1:0]      next_work_s;
    logic [DW-1:0]      signed_prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;
    logic               fix_dbz_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             negative);
        logic [WIDTH-1:0] result;
        if (negative) begin
            result = -value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Operand magnitudes and sign flags captured when an operation is accepted.
    always_comb begin
        is_signed_s = ~operation[0];
        sign_a_s    = is_signed_s & operand_a[WIDTH-1];
        sign_b_s    = is_signed_s & operand_b[WIDTH-1];
        mag_a_s     = magnitude(operand_a, sign_a_s);
        mag_b_s     = magnitude(operand_b, sign_b_s);
    end

    // One iteration: shift-add multiply, or one restoring-divide step.
    // work_r holds {accumulator/remainder, multiplier/dividend-quotient}.
    always_comb begin
        sum_s       = {1'b0, work_r[DW-1:WIDTH]}
                    + (work_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
        rem_ext_s   = {work_r[DW-1:WIDTH], work_r[WIDTH-1]};
        diff_s      = rem_ext_s - {1'b0, mag_b_r};
        next_work_s = work_r;
        if (op_r[1] == 1'b0) begin
            next_work_s = {sum_s, work_r[WIDTH-1:1]};
        end else if (diff_s[WIDTH] == 1'b0) begin
            next_work_s = {diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
        end else begin
            next_work_s = {rem_ext_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero substitution applied in FIXUP.
    always_comb begin
        signed_prod_s = work_r;
        fix_hi_s      = {WIDTH{1'b0}};
        fix_lo_s      = {WIDTH{1'b0}};
        fix_dbz_s     = 1'b0;
        case (op_r)
            2'b00: begin
                if (sign_a_r ^ sign_b_r) begin
                    signed_prod_s = -work_r;
                end else begin
                    signed_prod_s = work_r;
                end
                fix_hi_s = signed_prod_s[DW-1:WIDTH];
                fix_lo_s = signed_prod_s[WIDTH-1:0];
            end
            2'b01: begin
                fix_hi_s = work_r[DW-1:WIDTH];
                fix_lo_s = work_r[WIDTH-1:0];
            end
            2'b10, 2'b11: begin
                if (mag_b_r == {WIDTH{1'b0}}) begin
                    // Rebuild the raw dividend from its magnitude and sign.
                    fix_dbz_s = 1'b1;
                    fix_hi_s  = magnitude(mag_a_r, sign_a_r);
                    fix_lo_s  = {WIDTH{1'b1}};
                end else begin
                    fix_hi_s  = magnitude(work_r[DW-1:WIDTH], sign_a_r);
                    fix_lo_s  = magnitude(work_r[WIDTH-1:0], sign_a_r ^ sign_b_r);
                end
            end
            default: begin
                fix_hi_s  = {WIDTH{1'b0}};
                fix_lo_s  = {WIDTH{1'b0}};
                fix_dbz_s = 1'b0;
            end
        endcase
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clock) begin
        if (!clear_) begin
            state_r  <= IDLE;
            op_r     <= 2'b00;
            mag_a_r  <= {WIDTH{1'b0}};
            mag_b_r  <= {WIDTH{1'b0}};
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
            work_r   <= {DW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r     <= operation;
                        mag_a_r  <= mag_a_s;
                        mag_b_r  <= mag_b_s;
                        sign_a_r <= sign_a_s;
                        sign_b_r <= sign_b_s;
                        count_r  <= {CNT_W{1'b0}};
                        // Multiply starts with a zero accumulator, divide with a zero remainder.
                        work_r   <= operation[1] ? {{WIDTH{1'b0}}, mag_a_s}
                                                 : {{WIDTH{1'b0}}, mag_b_s};
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    work_r  <= next_work_s;
                    count_r <= count_r + CNT_W'(1);
                    busy_r  <= 1'b1;
                    if (count_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= FIXUP;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIXUP: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    dbz_r   <= fix_dbz_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign hi_out         = hi_r;
    assign lo_out         = lo_r;
    assign divide_by_zero = dbz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, corner sequences
// and randomized operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic              clock = 1'b0;
    logic              clear_;
    logic              start;
    logic [1:0]        operation;
    logic [WIDTH-1:0]  operand_a;
    logic [WIDTH-1:0]  operand_b;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi_out;
    logic [WIDTH-1:0]  lo_out;
    logic              divide_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        dbz;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .clear_         (clear_),
        .start          (start),
        .operation      (operation),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .busy           (busy),
        .done           (done),
        .hi_out         (hi_out),
        .lo_out         (lo_out),
        .divide_by_zero (divide_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {divide_by_zero, hi, lo} from 64-bit integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        logic [64:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                p   = 64'(sa * sb);
                res = {1'b0, p};
            end
            2'b01: begin
                p   = {32'h0, a} * {32'h0, b};
                res = {1'b0, p};
            end
            2'b10: begin
                if (b == 32'h0) begin
                    res = {1'b1, a, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {1'b0, r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) begin
                    res = {1'b1, a, 32'hFFFF_FFFF};
                end else begin
                    res = {1'b0, a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    // Present a request; returns #1 after the accepting edge N.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        operation = op;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("done_low_after_start", {63'd0, done}, 64'd0);
    endtask

    // Wait for done (bounded), checking latency, busy count and held outputs.
    task automatic wait_done(input int offset, input string tag);
        int          cycles   = offset;
        int          busy_cnt = 0;
        logic [31:0] h0       = hi_out;
        logic [31:0] l0       = lo_out;
        bit          held     = 1'b1;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (hi_out !== h0 || lo_out !== l0) held = 1'b0;
            @(posedge clock);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 64'(cycles), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(33 - offset));
        check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_outputs_held"}, {63'd0, held}, 64'd1);
    endtask

    task automatic check_result(input string tag, input logic dbz,
                                input logic [31:0] hi, input logic [31:0] lo);
        check({tag, "_hi"}, {32'd0, hi_out}, {32'd0, hi});
        check({tag, "_lo"}, {32'd0, lo_out}, {32'd0, lo});
        check({tag, "_dbz"}, {63'd0, divide_by_zero}, {63'd0, dbz});
    endtask

    initial begin
        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{2'b11, 32'd100,       32'd7,         1'b0, 32'd2,         32'd14};
        vecs[4] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'd1,         32'hFFFF_FFFD};
        vecs[6] = '{2'b11, 32'd5,         32'd0,         1'b1, 32'd5,         32'hFFFF_FFFF};
        vecs[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000};
        vecs[8] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[9] = '{2'b00, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'h0000_0000};

        clear_    = 1'b0;
        start     = 1'b0;
        operation = 2'b00;
        operand_a = 32'h0;
        operand_b = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check_result("reset", 1'b0, 32'h0, 32'h0);
        clear_ = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(0, $sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i), vecs[i].dbz, vecs[i].hi, vecs[i].lo);
        end

        // Start during busy is ignored; a start in the done cycle is taken.
        @(posedge clock);
        #1;
        issue(2'b01, 32'd3, 32'd4);
        repeat (4) @(posedge clock);
        #1;
        operation = 2'b01;
        operand_a = 32'd9;
        operand_b = 32'd9;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        wait_done(5, "ignored_start");
        check_result("ignored_start", 1'b0, 32'd0, 32'd12);
        issue(2'b01, 32'd2, 32'd2);
        wait_done(0, "back_to_back");
        check_result("back_to_back", 1'b0, 32'd0, 32'd4);

        // Mid-operation reset after a divide-by-zero result.
        issue(2'b11, 32'd9, 32'd0);
        wait_done(0, "dbz_pre");
        check_result("dbz_pre", 1'b1, 32'd9, 32'hFFFF_FFFF);
        issue(2'b11, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        #1;
        clear_ = 1'b0;
        @(posedge clock);
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check_result("abort", 1'b0, 32'h0, 32'h0);
        clear_ = 1'b1;
        begin
            int pulses = 0;
            repeat (40) begin
                @(posedge clock);
                #1;
                if (done) pulses++;
            end
            check("abort_no_done", 64'(pulses), 64'd0);
        end
        issue(2'b01, 32'd6, 32'd7);
        wait_done(0, "after_abort");
        check_result("after_abort", 1'b0, 32'd0, 32'd42);

        // Randomized operations against the reference model, back to back.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            logic [64:0] exp;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            if ($urandom_range(0, 7) == 0) b = b & 32'h0000_00FF;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
            exp = model(op, a, b);
            issue(op, a, b);
            wait_done(0, $sformatf("rand%0d", i));
            check_result($sformatf("rand%0d_op%0d", i, op), exp[64], exp[63:32], exp[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit for the MIPS datapath, executing MULT, MULTU, DIV and DIVU. It sits directly upstream of the HI and LO 32-bit PIPO registers. hi_out/lo_out drive their parallel inputs, and the done pulse drives their enable. The unit computes one result bit per clock (shift-add multiply, restoring divide) and holds its results until the next operation completes.

Parameters:
WIDTH, 32, operand width; hi_out/lo_out are WIDTH bits each, and an iteration count of WIDTH is fixed by it.

Ports:
clock  input  1  rising-edge clock
clear_  input  1  synchronous, active-low reset
start  input  1  request a new operation; sampled only in IDLE
operation  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  input  WIDTH  rs value (multiplicand / dividend)
operand_b  input  WIDTH  rt value (multiplier / divisor)
busy  output  1  operation in progress
done  output  1  one-cycle pulse when results are valid; HI/LO register enable
hi_out  output  WIDTH  MULT*: upper product half; DIV*: remainder
lo_out  output  WIDTH  MULT*: lower product half; DIV*: quotient
divide_by_zero  output  1  valid with done; set for DIV/DIVU with operand_b==0

Behaviour:
- One clock. Reset is synchronous and active-low: clear_ low at a rising edge forces IDLE, busy=0, done=0, divide_by_zero=0, hi_out=0, lo_out=0, and the iteration counter to 0. Reset overrides all other inputs, including mid-operation; the aborted operation produces no done.
- States: IDLE, RUN, FIXUP.
- IDLE, start=1 at edge N:
  - Latch operation.
  - Latch the magnitudes of operands (two's-complement absolute value for signed ops).
  - Latch the sign flags.
  - Counter <= 0; state <= RUN.
- IDLE, start=0: stay in IDLE.
- RUN: one iteration per edge at N+1 .. N+WIDTH. After iteration WIDTH (counter == WIDTH-1), state <= FIXUP.
- FIXUP, edge N+WIDTH+1:
  - Apply sign correction.
  - Write hi_out/lo_out and divide_by_zero.
  - done <= 1; state <= IDLE.
- Timing:
  - busy=1 exactly in the WIDTH+1 cycles after edges N..N+WIDTH.
  - done=1 exactly in the cycle after edge N+WIDTH+1; busy=0 in that cycle.
- done is registered and deasserts at the next edge.
- start is accepted during the done cycle, because the state is IDLE, giving back-to-back operations.
- start while busy is ignored and is not queued. Changes on operation/operand_a/operand_b during RUN/FIXUP have no effect.
- Multiply: 2*WIDTH-bit unsigned product of the magnitudes. For MULT, negate the full 2*WIDTH result if the operand signs differ. hi_out = upper half, lo_out = lower half. MULTU uses the raw operands.
- Divide: restoring division on the magnitudes. Quotient truncates toward zero.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0, with no flag.
- Divide by zero (DIV/DIVU, operand_b==0): same latency, divide_by_zero=1, lo_out = all ones, hi_out = raw operand_a.
- divide_by_zero is cleared on any later completed operation.
- hi_out/lo_out hold their values between completions and never show intermediate values.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at edge N -> busy high 33 cycles; done high exactly in the cycle after edge N+33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) * 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIVU 100 / 7 -> lo=14, hi=2. Then DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
- DIVU 5 / 0 -> divide_by_zero=1, lo=0xFFFFFFFF, hi=5 at the normal latency. Then DIV 0x80000000 / 0xFFFFFFFF -> divide_by_zero=0, lo=0x80000000, hi=0.
- Start MULTU 3*4; pulse start with different operands at edge N+5. Then start a new MULTU 2*2 in the done cycle -> first result hi=0, lo=12; the second request is ignored; the back-to-back op gives lo=4 after a further 33 busy cycles.
- Start DIVU; drive clear_ low at edge N+10 -> busy=0, done never pulses, hi/lo=0. Then release and run MULTU 6*7 -> lo=42.
